vscale_top: RTL and testbench



---
 rtl/vscale_top.sv | 228 ++++++++++++++++++++++
 tb/tb_vscale_top.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/vscale_top.sv
// Single-cycle RV32I-subset core with a unified word memory and an HTIF PCR port.
// Define VSCALE_CYCLE_CSR_EN to add a read-only 64-bit cycle counter CSR.

module vscale_imem #(
  parameter int unsigned MEM_DEPTH = 4096,
  parameter int unsigned AW        = 12
) (
  input  logic          clk,
  input  logic [AW-1:0] fetch_idx,
  output logic [31:0]   fetch_data,
  input  logic [AW-1:0] data_idx,
  output logic [31:0]   load_data,
  input  logic          store_en,
  input  logic [31:0]   store_data
);
  logic [31:0] mem [MEM_DEPTH];

  assign fetch_data = mem[fetch_idx];
  assign load_data  = mem[data_idx];

  always_ff @(posedge clk) begin
    if (store_en) mem[data_idx] <= store_data;
  end
endmodule

module vscale_top #(
  parameter int unsigned HTIF_PCR_WIDTH   = 64,
  parameter int unsigned MEM_DEPTH        = 4096,
  parameter logic [31:0] RESET_PC         = 32'h200,
  parameter logic [11:0] CSR_ADDR_TO_HOST = 12'h780
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      htif_pcr_req_valid,
  output logic                      htif_pcr_req_ready,
  input  logic                      htif_pcr_req_rw,
  input  logic [11:0]               htif_pcr_req_addr,
  input  logic [HTIF_PCR_WIDTH-1:0] htif_pcr_req_data,
  output logic                      htif_pcr_resp_valid,
  input  logic                      htif_pcr_resp_ready,
  output logic [HTIF_PCR_WIDTH-1:0] htif_pcr_resp_data
);
  localparam int unsigned AW = $clog2(MEM_DEPTH);
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  localparam logic [11:0] CSR_CYCLE  = 12'hC00;
  localparam logic [11:0] CSR_CYCLEH = 12'hC80;

  logic [31:0] pc, pc_plus4, next_pc, inst, load_data, data_addr;
  logic [31:0] regs [32];
  logic [31:0] rs1_val, rs2_val, alu_b, alu_out, rd_val;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic [31:0] csr_rdata, csr_src, csr_wval;
  logic [HTIF_PCR_WIDTH-1:0] tohost, pcr_rdata;
  logic [6:0]  opcode;
  logic [4:0]  rd, rs1, rs2, shamt;
  logic [2:0]  f3;
  logic [11:0] csr_addr;
  logic        rd_we, store_en, csr_hit, csr_we, br_taken, pcr_accept;
  logic        unused_bits;

  assign opcode   = inst[6:0];
  assign rd       = inst[11:7];
  assign f3       = inst[14:12];
  assign rs1      = inst[19:15];
  assign rs2      = inst[24:20];
  assign csr_addr = inst[31:20];
  assign imm_i    = {{20{inst[31]}}, inst[31:20]};
  assign imm_s    = {{20{inst[31]}}, inst[31:25], inst[11:7]};
  assign imm_b    = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
  assign imm_u    = {inst[31:12], 12'b0};
  assign imm_j    = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};

  assign rs1_val   = (rs1 == 5'd0) ? 32'd0 : regs[rs1];
  assign rs2_val   = (rs2 == 5'd0) ? 32'd0 : regs[rs2];
  assign pc_plus4  = pc + 32'd4;
  assign data_addr = rs1_val + ((opcode == OP_STORE) ? imm_s : imm_i);

  assign htif_pcr_req_ready = !htif_pcr_resp_valid || htif_pcr_resp_ready;
  assign pcr_accept         = htif_pcr_req_valid && htif_pcr_req_ready;

  // Word-indexed memory; address bits above the array size wrap.
  vscale_imem #(.MEM_DEPTH(MEM_DEPTH), .AW(AW)) imem (
    .clk        (clk),
    .fetch_idx  (pc[AW+1:2]),
    .fetch_data (inst),
    .data_idx   (data_addr[AW+1:2]),
    .load_data  (load_data),
    .store_en   (store_en),
    .store_data (rs2_val)
  );

  assign unused_bits = ^{pc[1:0], pc[31:AW+2], data_addr[1:0], data_addr[31:AW+2]};

`ifdef VSCALE_CYCLE_CSR_EN
  logic [63:0] cycle;

  always_ff @(posedge clk) begin
    if (reset) cycle <= '0;
    else       cycle <= cycle + 64'd1;
  end
`endif

  // ALU shared by OP and OP-IMM; SUB only exists in the register form.
  always_comb begin
    alu_b = (opcode == OP_OP) ? rs2_val : imm_i;
    shamt = alu_b[4:0];
    case (f3)
      3'b000:  alu_out = (opcode == OP_OP && inst[30]) ? rs1_val - alu_b : rs1_val + alu_b;
      3'b001:  alu_out = rs1_val << shamt;
      3'b010:  alu_out = {31'b0, $signed(rs1_val) < $signed(alu_b)};
      3'b011:  alu_out = {31'b0, rs1_val < alu_b};
      3'b100:  alu_out = rs1_val ^ alu_b;
      3'b101:  alu_out = inst[30] ? $unsigned($signed(rs1_val) >>> shamt) : rs1_val >> shamt;
      3'b110:  alu_out = rs1_val | alu_b;
      default: alu_out = rs1_val & alu_b;
    endcase
  end

  always_comb begin
    case (f3)
      3'b000:  br_taken = rs1_val == rs2_val;
      3'b001:  br_taken = rs1_val != rs2_val;
      3'b100:  br_taken = $signed(rs1_val) <  $signed(rs2_val);
      3'b101:  br_taken = $signed(rs1_val) >= $signed(rs2_val);
      3'b110:  br_taken = rs1_val <  rs2_val;
      3'b111:  br_taken = rs1_val >= rs2_val;
      default: br_taken = 1'b0;
    endcase
  end

  // Core-side CSR view (32-bit) and host-side PCR view (full width).
  always_comb begin
    csr_hit   = 1'b0;
    csr_rdata = '0;
    pcr_rdata = '0;
    if (csr_addr == CSR_ADDR_TO_HOST) begin
      csr_hit   = 1'b1;
      csr_rdata = tohost[31:0];
    end
`ifdef VSCALE_CYCLE_CSR_EN
    else if (csr_addr == CSR_CYCLE) begin
      csr_hit   = 1'b1;
      csr_rdata = cycle[31:0];
    end else if (csr_addr == CSR_CYCLEH) begin
      csr_hit   = 1'b1;
      csr_rdata = cycle[63:32];
    end
    if (htif_pcr_req_addr == CSR_CYCLE) pcr_rdata = HTIF_PCR_WIDTH'(cycle);
`endif
    if (htif_pcr_req_addr == CSR_ADDR_TO_HOST) pcr_rdata = tohost;
  end

  assign csr_src = f3[2] ? {27'b0, rs1} : rs1_val;

  always_comb begin
    case (f3[1:0])
      2'b01:   csr_wval = csr_src;
      2'b10:   csr_wval = csr_rdata | csr_src;
      default: csr_wval = csr_rdata & ~csr_src;
    endcase
  end

  // Decode and writeback selection; unknown encodings fall through as NOPs.
  always_comb begin
    next_pc  = pc_plus4;
    rd_we    = 1'b0;
    rd_val   = '0;
    store_en = 1'b0;
    csr_we   = 1'b0;
    case (opcode)
      OP_LUI:   begin rd_we = 1'b1; rd_val = imm_u; end
      OP_AUIPC: begin rd_we = 1'b1; rd_val = pc + imm_u; end
      OP_JAL:   begin rd_we = 1'b1; rd_val = pc_plus4; next_pc = pc + imm_j; end
      OP_JALR: begin
        if (f3 == 3'b000) begin
          rd_we   = 1'b1;
          rd_val  = pc_plus4;
          next_pc = (rs1_val + imm_i) & ~32'd1;
        end
      end
      OP_BRANCH: if (br_taken) next_pc = pc + imm_b;
      OP_LOAD:   if (f3 == 3'b010) begin rd_we = 1'b1; rd_val = load_data; end
      OP_STORE:  if (f3 == 3'b010) store_en = 1'b1;
      OP_IMM, OP_OP: begin rd_we = 1'b1; rd_val = alu_out; end
      OP_SYSTEM: begin
        if (csr_hit && f3[1:0] != 2'b00) begin
          rd_we  = 1'b1;
          rd_val = csr_rdata;
          csr_we = (csr_addr == CSR_ADDR_TO_HOST) && (f3[1:0] == 2'b01 || rs1 != 5'd0);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc                  <= RESET_PC;
      tohost              <= '0;
      htif_pcr_resp_valid <= 1'b0;
      htif_pcr_resp_data  <= '0;
      for (int i = 1; i < 32; i++) regs[i] <= '0;
    end else begin
      pc <= next_pc;
      if (rd_we && rd != 5'd0) regs[rd] <= rd_val;
      if (pcr_accept) begin
        htif_pcr_resp_valid <= 1'b1;
        htif_pcr_resp_data  <= pcr_rdata;
      end else if (htif_pcr_resp_ready) begin
        htif_pcr_resp_valid <= 1'b0;
      end
      // tohost priority: core write, then host write, then host read-clear.
      if (csr_we)
        tohost <= HTIF_PCR_WIDTH'(csr_wval);
      else if (pcr_accept && htif_pcr_req_addr == CSR_ADDR_TO_HOST)
        tohost <= htif_pcr_req_rw ? htif_pcr_req_data : '0;
    end
  end
endmodule

// File: tb/tb_vscale_top.sv
// Directed bench for vscale_top: host loads programs, polls tohost over PCR,
// and a response scoreboard checks every PCR reply.

module tb_vscale_top;
  logic        clk = 1'b0;
  logic        reset;
  logic        htif_pcr_req_valid, htif_pcr_req_ready, htif_pcr_req_rw;
  logic [11:0] htif_pcr_req_addr;
  logic [63:0] htif_pcr_req_data;
  logic        htif_pcr_resp_valid, htif_pcr_resp_ready;
  logic [63:0] htif_pcr_resp_data;

  int          checks = 0;
  int          errors = 0;
  logic [63:0] sb [$];
  logic [31:0] prog [$];

  localparam logic [11:0] TOHOST = 12'h780;
  localparam logic [63:0] BIGVAL = 64'hCAFEF00D_12345678;

  vscale_top DUT (
    .clk                 (clk),
    .reset               (reset),
    .htif_pcr_req_valid  (htif_pcr_req_valid),
    .htif_pcr_req_ready  (htif_pcr_req_ready),
    .htif_pcr_req_rw     (htif_pcr_req_rw),
    .htif_pcr_req_addr   (htif_pcr_req_addr),
    .htif_pcr_req_data   (htif_pcr_req_data),
    .htif_pcr_resp_valid (htif_pcr_resp_valid),
    .htif_pcr_resp_ready (htif_pcr_resp_ready),
    .htif_pcr_resp_data  (htif_pcr_resp_data)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] enc_i(input int imm, input int rs1, input logic [2:0] f3,
                                        input int rd, input logic [6:0] op);
    logic [11:0] im;
    im = 12'(imm);
    return {im, 5'(rs1), f3, 5'(rd), op};
  endfunction

  function automatic logic [31:0] enc_s(input int imm, input int rs2, input int rs1);
    logic [11:0] im;
    im = 12'(imm);
    return {im[11:5], 5'(rs2), 5'(rs1), 3'b010, im[4:0], 7'h23};
  endfunction

  function automatic logic [31:0] enc_b(input int off, input int rs2, input int rs1, input logic [2:0] f3);
    logic [12:0] im;
    im = 13'(off);
    return {im[12], im[10:5], 5'(rs2), 5'(rs1), f3, im[4:1], im[11], 7'h63};
  endfunction

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input int rs2, input int rs1,
                                        input logic [2:0] f3, input int rd);
    return {f7, 5'(rs2), 5'(rs1), f3, 5'(rd), 7'h33};
  endfunction

  function automatic logic [31:0] enc_lui(input int imm20, input int rd);
    return {20'(imm20), 5'(rd), 7'h37};
  endfunction

  function automatic logic [31:0] enc_j(input int off, input int rd);
    logic [20:0] im;
    im = 21'(off);
    return {im[20], im[10:1], im[11], im[19:12], 5'(rd), 7'h6F};
  endfunction

  function automatic logic [31:0] addi(input int rd, input int rs1, input int imm);
    return enc_i(imm, rs1, 3'b000, rd, 7'h13);
  endfunction

  function automatic logic [31:0] csrw_tohost(input int rs1);
    return enc_i(32'h780, rs1, 3'b001, 0, 7'h73);
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Clears memory and places prog at 0x200 (word 128); caller holds reset.
  task automatic load_prog();
    for (int i = 0; i < 4096; i++) DUT.imem.mem[i] = 32'h0;
    for (int i = 0; i < prog.size(); i++) DUT.imem.mem[128 + i] = prog[i];
  endtask

  task automatic do_reset();
    reset = 1'b1;
    htif_pcr_req_valid = 1'b0;
    load_prog();
    repeat (2) begin @(posedge clk); #1; end
    reset = 1'b0;
  endtask

  // One PCR cycle with resp_ready=1; an accepted request pushes its expected reply.
  task automatic step(input logic v, input logic rw, input logic [11:0] a, input logic [63:0] d,
                      input logic [63:0] exp, input string tag);
    htif_pcr_req_valid  = v;
    htif_pcr_req_rw     = rw;
    htif_pcr_req_addr   = a;
    htif_pcr_req_data   = d;
    htif_pcr_resp_ready = 1'b1;
    #1;
    if (v) begin
      check({tag, " req_ready"}, 64'(htif_pcr_req_ready), 64'd1);
      sb.push_back(exp);
    end
    @(posedge clk); #1;
    htif_pcr_req_valid = 1'b0;
    if (htif_pcr_resp_valid) begin
      if (sb.size() == 0) check({tag, " unexpected resp_valid"}, 64'(htif_pcr_resp_valid), 64'd0);
      else                check(tag, htif_pcr_resp_data, sb.pop_front());
    end else if (sb.size() != 0) begin
      check({tag, " resp_valid"}, 64'(htif_pcr_resp_valid), 64'd1);
      sb.delete();
    end
  endtask

  initial begin
    reset = 1'b1;
    htif_pcr_req_valid = 1'b0;
    htif_pcr_req_rw = 1'b0;
    htif_pcr_req_addr = TOHOST;
    htif_pcr_req_data = '0;
    htif_pcr_resp_ready = 1'b1;

    // Pass program, loaded while reset is held with a pending tohost read.
    prog.delete();
    prog.push_back(addi(1, 0, 144));
    prog.push_back(csrw_tohost(1));
    prog.push_back(enc_j(0, 0));
    load_prog();
    htif_pcr_req_valid = 1'b1;
    repeat (10) begin
      @(posedge clk); #1;
      check("reset resp_data", htif_pcr_resp_data, 64'd0);
      check("reset resp_valid", 64'(htif_pcr_resp_valid), 64'd0);
    end
    reset = 1'b0;
    htif_pcr_req_valid = 1'b0;
    check("pc after reset", 64'(DUT.pc), 64'h200);

    // Edge 2 collides core csrw with a PCR read: old value returned, write kept.
    step(1, 0, TOHOST, '0, 64'd0,   "pass poll e1");
    step(1, 0, TOHOST, '0, 64'd0,   "pass poll e2");
    step(1, 0, TOHOST, '0, 64'd144, "pass poll e3");
    step(1, 0, TOHOST, '0, 64'd0,   "pass read-clear e4");
    step(1, 0, TOHOST, '0, 64'd0,   "pass read-clear e5");

    // Unimplemented PCR address reads 0 and ignores writes.
    step(1, 1, 12'h123, 64'd55, 64'd0, "unimpl write");
    step(1, 0, 12'h123, '0,     64'd0, "unimpl read");

    // Fail program reports 7 (code 3).
    prog.delete();
    prog.push_back(addi(1, 0, 7));
    prog.push_back(csrw_tohost(1));
    do_reset();
    repeat (3) step(0, 0, TOHOST, '0, '0, "fail idle");
    step(1, 0, TOHOST, '0, 64'd7, "fail tohost");
    step(1, 0, TOHOST, '0, 64'd0, "fail read-clear");

    // ALU / branch / memory self-test; reports 144 only if every check passes.
    prog.delete();
    prog.push_back(enc_lui(32'hDEADC, 2));              // 0x200
    prog.push_back(addi(2, 2, -273));                   // 0x204 x2=DEADBEEF
    prog.push_back(addi(3, 0, 32'h400));                // 0x208
    prog.push_back(enc_s(0, 2, 3));                     // 0x20C sw
    prog.push_back(enc_i(0, 3, 3'b010, 4, 7'h03));      // 0x210 lw
    prog.push_back(enc_b(32'h48, 2, 4, 3'b001));        // 0x214 -> fail
    prog.push_back(addi(5, 0, -1));                     // 0x218
    prog.push_back(addi(6, 0, 1));                      // 0x21C
    prog.push_back(enc_r(7'h00, 6, 5, 3'b010, 7));      // 0x220 slt
    prog.push_back(enc_r(7'h00, 6, 5, 3'b011, 8));      // 0x224 sltu
    prog.push_back(addi(9, 0, 1));                      // 0x228
    prog.push_back(enc_b(32'h30, 9, 7, 3'b001));        // 0x22C -> fail
    prog.push_back(enc_b(32'h2C, 0, 8, 3'b001));        // 0x230 -> fail
    prog.push_back(addi(10, 0, 10));                    // 0x234
    prog.push_back(addi(11, 0, 0));                     // 0x238
    prog.push_back(addi(11, 11, 1));                    // 0x23C loop
    prog.push_back(addi(10, 10, -1));                   // 0x240
    prog.push_back(enc_b(-8, 0, 10, 3'b001));           // 0x244 -> loop
    prog.push_back(addi(12, 0, 10));                    // 0x248
    prog.push_back(enc_b(32'h10, 12, 11, 3'b001));      // 0x24C -> fail
    prog.push_back(addi(1, 0, 144));                    // 0x250
    prog.push_back(csrw_tohost(1));                     // 0x254
    prog.push_back(enc_j(0, 0));                        // 0x258
    prog.push_back(addi(1, 0, 7));                      // 0x25C fail
    prog.push_back(csrw_tohost(1));                     // 0x260
    prog.push_back(enc_j(0, 0));                        // 0x264
    do_reset();
    repeat (80) step(0, 0, TOHOST, '0, '0, "alu idle");
    step(1, 0, TOHOST, '0, 64'd144, "alu program result");
    step(1, 0, TOHOST, '0, 64'd0,   "alu read-clear");
    check("sw/lw round trip", 64'(DUT.imem.mem[256]), 64'hDEADBEEF);

    // Full-width host write, then a read held under backpressure.
    step(1, 1, TOHOST, BIGVAL, 64'd0, "pcr write");
    step(0, 0, TOHOST, '0, '0, "pcr drain");
    htif_pcr_req_valid  = 1'b1;
    htif_pcr_req_rw     = 1'b0;
    htif_pcr_req_addr   = TOHOST;
    htif_pcr_resp_ready = 1'b0;
    #1;
    check("bp first req_ready", 64'(htif_pcr_req_ready), 64'd1);
    sb.push_back(BIGVAL);
    @(posedge clk); #1;
    repeat (3) begin
      check("bp resp_valid held", 64'(htif_pcr_resp_valid), 64'd1);
      check("bp resp_data held", htif_pcr_resp_data, sb[0]);
      check("bp req_ready low", 64'(htif_pcr_req_ready), 64'd0);
      @(posedge clk); #1;
    end
    check("bp final resp_data", htif_pcr_resp_data, sb.pop_front());
    htif_pcr_req_valid  = 1'b0;
    htif_pcr_resp_ready = 1'b1;
    @(posedge clk); #1;
    check("bp resp_valid dropped", 64'(htif_pcr_resp_valid), 64'd0);
    step(1, 0, TOHOST, '0, 64'd0, "bp single read-clear");

    // Core write of 5 beats the read-clear of a host-written 9.
    prog.delete();
    prog.push_back(addi(1, 0, 5));
    prog.push_back(csrw_tohost(1));
    prog.push_back(enc_j(0, 0));
    do_reset();
    step(1, 1, TOHOST, 64'd9, 64'd0, "collide host write");
    step(1, 0, TOHOST, '0,    64'd9, "collide read old");
    step(1, 0, TOHOST, '0,    64'd5, "collide core wins");
    step(1, 0, TOHOST, '0,    64'd0, "collide read-clear");

    check("scoreboard drained", 64'(sb.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
